// File: rtl/video_pattern_pkg.sv
// rtl/video_pattern_pkg.sv - pattern IDs and selection helpers for the VGA test-pattern generator
package video_pattern_pkg;

  localparam logic [3:0] PAT_OFF    = 4'd0;
  localparam logic [3:0] PAT_RED    = 4'd1;
  localparam logic [3:0] PAT_GRN    = 4'd2;
  localparam logic [3:0] PAT_BLU    = 4'd3;
  localparam logic [3:0] PAT_BARS   = 4'd4;
  localparam logic [3:0] PAT_BORDER = 4'd5;
  localparam logic [3:0] PAT_CHECK  = 4'd6;
  localparam logic [3:0] PAT_SCROLL = 4'd7;
  localparam logic [3:0] PAT_RAMP   = 4'd8;

  localparam int NUM_PATTERNS = 9;
  localparam int BORDER_WIDTH = 8;

  // Unknown IDs collapse to black so the displayed ID always names a real pattern.
  function automatic logic [3:0] sanitize_pattern(input logic [3:0] id);
    return (int'(id) < NUM_PATTERNS) ? id : PAT_OFF;
  endfunction

  function automatic logic [3:0] next_auto_pattern(input logic [3:0] cur);
    return (cur >= PAT_RED && cur < PAT_RAMP) ? cur + 4'd1 : PAT_RED;
  endfunction

endpackage

// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - frame counter, auto-cycle counter and frame-synchronous pattern selection
module pattern_sequencer
  import video_pattern_pkg::*;
#(
  parameter int AUTO_FRAMES = 120
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_pattern,
  input  logic       i_auto,
  input  logic       i_frame_strobe,
  output logic [3:0] o_active_pattern,
  output logic [6:0] o_frame_cnt
);

  localparam int ACNT_W = $clog2(AUTO_FRAMES + 1);
  localparam logic [ACNT_W-1:0] AUTO_LAST = ACNT_W'(AUTO_FRAMES - 1);

  logic [ACNT_W-1:0] auto_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_active_pattern <= PAT_OFF;
      o_frame_cnt      <= '0;
      auto_cnt         <= '0;
    end else begin
      if (i_frame_strobe) o_frame_cnt <= o_frame_cnt + 7'd1;
      // Auto count restarts whenever manual mode is selected, so each engagement gets a full period.
      if (!i_auto) begin
        auto_cnt <= '0;
        if (i_frame_strobe) o_active_pattern <= sanitize_pattern(i_pattern);
      end else if (i_frame_strobe) begin
        if (auto_cnt == AUTO_LAST) begin
          auto_cnt         <= '0;
          o_active_pattern <= next_auto_pattern(o_active_pattern);
        end else begin
          auto_cnt <= auto_cnt + ACNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - two-stage VGA test-pattern datapath with delay-matched sync/visible
module video_pattern_gen
  import video_pattern_pkg::*;
#(
  parameter int VIDEO_WIDTH = 3,
  parameter int H_VISIBLE   = 640,
  parameter int V_VISIBLE   = 480,
  parameter int AUTO_FRAMES = 120,
  parameter int CHECK_LOG2  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [3:0]             i_pattern,
  input  logic                   i_auto,
  input  logic [9:0]             i_hpos,
  input  logic [9:0]             i_vpos,
  input  logic                   i_visible,
  input  logic                   i_hsync,
  input  logic                   i_vsync,
  input  logic                   i_frame_strobe,
  output logic [VIDEO_WIDTH-1:0] o_red_video,
  output logic [VIDEO_WIDTH-1:0] o_grn_video,
  output logic [VIDEO_WIDTH-1:0] o_blu_video,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic                   o_visible,
  output logic [3:0]             o_active_pattern
);

  localparam int W         = VIDEO_WIDTH;
  localparam int BAR_W     = (H_VISIBLE / 8 > 0) ? H_VISIBLE / 8 : 1;
  localparam int RAMP_STEP = ((H_VISIBLE >> W) > 0) ? (H_VISIBLE >> W) : 1;
  localparam int RC_W      = (RAMP_STEP > 1) ? $clog2(RAMP_STEP) : 1;
  localparam int S_W       = (W + 4 > 11) ? W + 4 : 11;
  localparam int SH_W      = W + 3;
  localparam logic [W-1:0]    FULL      = '1;
  localparam logic [RC_W-1:0] RAMP_LAST = RC_W'(RAMP_STEP - 1);

  logic [3:0] active_pattern;
  logic [6:0] frame_cnt;

  pattern_sequencer #(
    .AUTO_FRAMES(AUTO_FRAMES)
  ) u_seq (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_pattern       (i_pattern),
    .i_auto          (i_auto),
    .i_frame_strobe  (i_frame_strobe),
    .o_active_pattern(active_pattern),
    .o_frame_cnt     (frame_cnt)
  );

  assign o_active_pattern = active_pattern;

  // Ramp state reflects pixels already seen on this line; hpos==0 restarts it for the current pixel.
  logic [RC_W-1:0] ramp_sub, ramp_sub_cur;
  logic [W-1:0]    ramp_lvl, ramp_lvl_cur;

  always_comb begin
    ramp_sub_cur = (i_hpos == '0) ? '0 : ramp_sub;
    ramp_lvl_cur = (i_hpos == '0) ? '0 : ramp_lvl;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ramp_sub <= '0;
      ramp_lvl <= '0;
    end else if (i_visible && ramp_sub_cur == RAMP_LAST) begin
      ramp_sub <= '0;
      ramp_lvl <= (ramp_lvl_cur == FULL) ? FULL : ramp_lvl_cur + W'(1);
    end else if (i_visible) begin
      ramp_sub <= ramp_sub_cur + RC_W'(1);
      ramp_lvl <= ramp_lvl_cur;
    end else begin
      ramp_sub <= ramp_sub_cur;
      ramp_lvl <= ramp_lvl_cur;
    end
  end

  // Stage 1: pattern-independent terms. s1_s holds the scroll sum shifted right by one.
  logic [2:0]      s1_bar;
  logic            s1_border, s1_check, s1_vis, s1_hs, s1_vs;
  logic [W-1:0]    s1_ramp;
  logic [SH_W-1:0] s1_s;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_bar    <= '0;
      s1_border <= 1'b0;
      s1_check  <= 1'b0;
      s1_ramp   <= '0;
      s1_s      <= '0;
      s1_vis    <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
    end else begin
      s1_bar    <= 3'(i_hpos / 10'(BAR_W));
      s1_border <= (i_hpos < 10'(BORDER_WIDTH)) || (i_hpos >= 10'(H_VISIBLE - BORDER_WIDTH)) ||
                   (i_vpos < 10'(BORDER_WIDTH)) || (i_vpos >= 10'(V_VISIBLE - BORDER_WIDTH));
      s1_check  <= i_hpos[CHECK_LOG2] ^ i_vpos[CHECK_LOG2];
      s1_ramp   <= ramp_lvl_cur;
      s1_s      <= SH_W'((S_W'(i_vpos) + S_W'(frame_cnt)) >> 1);
      s1_vis    <= i_visible;
      s1_hs     <= i_hsync;
      s1_vs     <= i_vsync;
    end
  end

  logic [W-1:0] red_n, grn_n, blu_n, intensity;
  assign intensity = s1_s[W-1:0];

  always_comb begin
    red_n = '0;
    grn_n = '0;
    blu_n = '0;
    case (active_pattern)
      PAT_RED: red_n = FULL;
      PAT_GRN: grn_n = FULL;
      PAT_BLU: blu_n = FULL;
      PAT_BARS: begin
        red_n = {W{~s1_bar[1]}};
        grn_n = {W{~s1_bar[2]}};
        blu_n = {W{~s1_bar[0]}};
      end
      PAT_BORDER: if (s1_border) begin
        red_n = FULL;
        grn_n = FULL;
        blu_n = FULL;
      end
      PAT_CHECK: if (s1_check) begin
        red_n = FULL;
        grn_n = FULL;
        blu_n = FULL;
      end
      PAT_SCROLL: begin
        red_n = s1_s[W+1] ? intensity : '0;
        grn_n = s1_s[W+2] ? intensity : '0;
        blu_n = s1_s[W]   ? intensity : '0;
      end
      PAT_RAMP: begin
        red_n = s1_ramp;
        grn_n = s1_ramp;
        blu_n = s1_ramp;
      end
      default: ;
    endcase
    if (!s1_vis) begin
      red_n = '0;
      grn_n = '0;
      blu_n = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_red_video <= '0;
      o_grn_video <= '0;
      o_blu_video <= '0;
      o_hsync     <= 1'b0;
      o_vsync     <= 1'b0;
      o_visible   <= 1'b0;
    end else begin
      o_red_video <= red_n;
      o_grn_video <= grn_n;
      o_blu_video <= blu_n;
      o_hsync     <= s1_hs;
      o_vsync     <= s1_vs;
      o_visible   <= s1_vis;
    end
  end

endmodule

// File: doc/video_pattern_gen.md
# video_pattern_gen

Parametrised, pipelined VGA test-pattern generator producing VIDEO_WIDTH-bit RGB from pixel position. It sits between the VGA sync/timing generator and the video output registers. Over a single-register pattern mux it adds:
- frame-synchronous pattern switching, so there is no mid-frame tearing;
- an auto-cycle mode;
- sync/visible signals delay-matched to the video pipeline.

## Interface
Parameters:
- VIDEO_WIDTH, 3, bits per colour channel (1..8)
- H_VISIBLE, 640, visible pixels per line
- V_VISIBLE, 480, visible lines per frame
- AUTO_FRAMES, 120, frame strobes per pattern in auto-cycle mode (≥1)
- CHECK_LOG2, 4, checkerboard square size = 2^CHECK_LOG2 pixels

Ports:
- i_clk  in  1  pixel clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_pattern  in  4  requested pattern ID
- i_auto  in  1  1 = auto-cycle patterns 1..8, ignoring i_pattern
- i_hpos  in  10  current pixel column
- i_vpos  in  10  current pixel row
- i_visible  in  1  pixel is in the visible area
- i_hsync  in  1  horizontal sync, passed through
- i_vsync  in  1  vertical sync, passed through
- i_frame_strobe  in  1  one-cycle pulse at start of frame
- o_red_video / o_grn_video / o_blu_video  out  VIDEO_WIDTH each  colour outputs
- o_hsync / o_vsync / o_visible  out  1 each  inputs delayed to match video
- o_active_pattern  out  4  pattern currently displayed

## Operation
Patterns. FULL = all ones; 0 = zero.
- 0: black.
- 1 / 2 / 3: solid red / green / blue at FULL.
- 4: 8 vertical bars of width H_VISIBLE/8. Bar index b: red=~b[1], grn=~b[2], blu=~b[0], each replicated to FULL.
- 5: white border, 8 px, on all four visible edges; interior black.
- 6: checkerboard. White where i_hpos[CHECK_LOG2] ^ i_vpos[CHECK_LOG2], else black.
- 7: scrolling gradient. s = i_vpos + frame_cnt, 11-bit with wrap. Intensity = s[VIDEO_WIDTH:1]. Red gated by s[VIDEO_WIDTH+2], grn by s[VIDEO_WIDTH+3], blu by s[VIDEO_WIDTH+1].
- 8: horizontal grey ramp, 2^VIDEO_WIDTH steps.
  - Step counter cleared when i_hpos==0.
  - Increments every RAMP_STEP = H_VISIBLE>>VIDEO_WIDTH visible pixels.
  - Saturates at FULL.
- IDs 9..15: treated as 0.

Pattern selection:
- Manual mode (i_auto=0): i_pattern is sampled only on i_frame_strobe; active_pattern takes the new value the following cycle. Mid-frame changes are deferred to the next strobe.
- Auto mode (i_auto=1): a frame counter counts strobes. On the AUTO_FRAMES-th strobe, active_pattern advances 1→2→…→8→1 and the counter clears.
  - If active_pattern is 0 or invalid when auto engages, the next advance goes to 1.
- Leaving auto mode: the next strobe loads i_pattern.
- frame_cnt: 7-bit, increments on every strobe, wraps 127→0.

## Timing
- Two-cycle pipeline.
  - Stage 1 registers pattern-independent terms: bar index, border flag, checker bit, ramp level, s.
  - Stage 2 registers the muxed, visible-gated RGB.
- o_hsync, o_vsync and o_visible are the inputs delayed exactly 2 cycles.
- RGB is 0 whenever the delayed visible is 0.
- Reset (async assert, sync release): all outputs 0, active_pattern=0, frame_cnt=0, auto counter=0, ramp counter=0, pipeline registers 0.
- Reset asserted mid-frame clears everything immediately. After release, outputs stay black until the first strobe loads a pattern.
- Strobe coincident with an i_auto toggle: the new i_auto value governs that strobe.
- Pattern change takes effect on pixel (0,0) at the output, 2 cycles after the strobe cycle.

## Structure
- Package video_pattern_pkg: pattern ID localparams (PAT_OFF, PAT_RED … PAT_RAMP = 8), NUM_PATTERNS = 9, BORDER_WIDTH = 8.
- Sub-module pattern_sequencer owns frame_cnt, the auto counter and active_pattern selection.
- The top level holds the pattern datapath and the delay pipeline.

## Test plan
- Reset mid-frame with i_pattern=1 → all outputs 0 immediately. After release, still 0 until a strobe; red=7 (W=3) appears 2 cycles after the strobe at a visible pixel.
- i_pattern 2→3 changed at line 100 → green continues to end of frame; blue from the next strobe, o_active_pattern=3.
- i_auto=1, AUTO_FRAMES=2, 18 strobes → active_pattern sequence 1,2,…,8,1, changing every 2 strobes.
- i_pattern=5, W=4, hpos 0..7 and 632..639 → output 15/15/15; hpos 8 → 0. Sync/visible outputs equal inputs delayed exactly 2 cycles.
- i_pattern=8, W=3, sweep one line → ramp levels 0..7, each held 80 pixels.
- i_pattern=12 → output 0, o_active_pattern=0. i_visible=0 with pattern 1 → RGB 0.
